// File: rtl/ace_master_ctrl_if.sv
// ace_master_ctrl_if: single-beat ACE master bus bundle.
// Carries the AR/R/AW/W/B channels plus the RACK/WACK acknowledges.
// Modports:
//   master - the coherent master (ace_master_ctrl) side
//   slave  - the interconnect side
// Handshake rule on every channel: a beat transfers on a rising edge where
// valid and ready are both high. Once valid is raised, it and its payload
// stay unchanged until that transfer. The source never waits for ready
// before raising valid.
interface ace_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4
);
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [ID_W-1:0]   ar_id;
    logic [3:0]        ar_snoop;
    logic [1:0]        ar_domain;

    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_resp;
    logic              r_last;

    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [ID_W-1:0]   aw_id;
    logic [2:0]        aw_snoop;
    logic [1:0]        aw_domain;

    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              w_last;

    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;

    logic              rack;
    logic              wack;

    modport master (
        output ar_valid, ar_addr, ar_id, ar_snoop, ar_domain,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last,
        output r_ready,
        output aw_valid, aw_addr, aw_id, aw_snoop, aw_domain,
        input  aw_ready,
        output w_valid, w_data, w_last,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output rack, wack
    );

    modport slave (
        input  ar_valid, ar_addr, ar_id, ar_snoop, ar_domain,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last,
        input  r_ready,
        input  aw_valid, aw_addr, aw_id, aw_snoop, aw_domain,
        output aw_ready,
        input  w_valid, w_data, w_last,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  rack, wack
    );
endinterface

// File: rtl/ace_master_ctrl.sv
// ace_master_ctrl: turns cache controller commands into single-beat ACE
// master transactions.
//   read_req    -> ReadShared  (AR, R, RACK)
//   invalid_req -> MakeUnique  (AR, R, RACK, fill_* untouched)
//   write_req   -> WriteBack   (AW+W, B, WACK)
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   read_req, write_req, invalid_req, req_addr, wb_data
//                     commands from the cache controller, held until ace_ready
//   ace_ready         one-cycle completion pulse (same cycle as rack/wack)
//   fill_data, fill_shared, fill_dirty
//                     data and IsShared/PassDirty captured from ReadShared
//   ace_error         sticky error flag (SLVERR/DECERR or missing r_last)
//   state_dbg         current FSM state
//   bus               ACE master modport
// All bus valid/ready/ack outputs are decoded from registered state, so no
// output depends combinationally on any input.
module ace_master_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,
    parameter int MASTER_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_req,
    input  logic              write_req,
    input  logic              invalid_req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ace_ready,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_shared,
    output logic              fill_dirty,
    output logic              ace_error,
    output logic [2:0]        state_dbg,
    ace_master_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AWW  = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_ACK  = 3'd5;

    localparam logic [3:0] SNOOP_READ_SHARED = 4'b0001;
    localparam logic [3:0] SNOOP_MAKE_UNIQUE = 4'b1100;
    localparam logic [2:0] SNOOP_WRITE_BACK  = 3'b011;
    localparam logic [1:0] DOMAIN_OUTER      = 2'b10;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ID_W-1:0]   id_q;
    logic [3:0]        ar_snoop_q;
    logic [2:0]        aw_snoop_q;
    logic [DATA_W-1:0] data_q;
    logic              aw_done;     // AW beat already accepted in this AWW visit
    logic              w_done;      // W beat already accepted in this AWW visit
    logic              is_read;     // selects rack (1) or wack (0) in ACK
    logic              is_mu;       // MakeUnique: R data is not a line fill

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            id_q        <= '0;
            ar_snoop_q  <= '0;
            aw_snoop_q  <= '0;
            data_q      <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            is_read     <= 1'b0;
            is_mu       <= 1'b0;
            fill_data   <= '0;
            fill_shared <= 1'b0;
            fill_dirty  <= 1'b0;
            ace_error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Fixed priority; lower-priority requests stay asserted
                    // by the cache controller and are picked up later.
                    if (write_req) begin
                        addr_q     <= req_addr;
                        data_q     <= wb_data;
                        id_q       <= ID_W'(MASTER_ID);
                        aw_snoop_q <= SNOOP_WRITE_BACK;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        is_read    <= 1'b0;
                        is_mu      <= 1'b0;
                        state      <= S_AWW;
                    end else if (invalid_req) begin
                        addr_q     <= req_addr;
                        id_q       <= ID_W'(MASTER_ID);
                        ar_snoop_q <= SNOOP_MAKE_UNIQUE;
                        is_read    <= 1'b1;
                        is_mu      <= 1'b1;
                        state      <= S_AR;
                    end else if (read_req) begin
                        addr_q     <= req_addr;
                        id_q       <= ID_W'(MASTER_ID);
                        ar_snoop_q <= SNOOP_READ_SHARED;
                        is_read    <= 1'b1;
                        is_mu      <= 1'b0;
                        state      <= S_AR;
                    end
                end
                S_AR: begin
                    if (bus.ar_ready) begin
                        state <= S_R;
                    end
                end
                S_R: begin
                    if (bus.r_valid) begin
                        if (!is_mu) begin
                            fill_data   <= bus.r_data;
                            fill_shared <= bus.r_resp[3];
                            fill_dirty  <= bus.r_resp[2];
                        end
                        if (bus.r_resp[1:0] >= 2'd2 || !bus.r_last) begin
                            ace_error <= 1'b1;
                        end
                        state <= S_ACK;
                    end
                end
                S_AWW: begin
                    if (bus.aw_valid && bus.aw_ready) begin
                        aw_done <= 1'b1;
                    end
                    if (bus.w_valid && bus.w_ready) begin
                        w_done <= 1'b1;
                    end
                    // Leave once both beats are accepted, counting a
                    // handshake happening in this very cycle.
                    if ((aw_done || bus.aw_ready) && (w_done || bus.w_ready)) begin
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (bus.b_valid) begin
                        if (bus.b_resp >= 2'd2) begin
                            ace_error <= 1'b1;
                        end
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ar_valid  = (state == S_AR);
    assign bus.ar_addr   = addr_q;
    assign bus.ar_id     = id_q;
    assign bus.ar_snoop  = ar_snoop_q;
    assign bus.ar_domain = DOMAIN_OUTER;

    assign bus.r_ready   = (state == S_R);

    assign bus.aw_valid  = (state == S_AWW) && !aw_done;
    assign bus.aw_addr   = addr_q;
    assign bus.aw_id     = id_q;
    assign bus.aw_snoop  = aw_snoop_q;
    assign bus.aw_domain = DOMAIN_OUTER;

    // Single-beat writes: the only W beat is always the last one.
    assign bus.w_valid   = (state == S_AWW) && !w_done;
    assign bus.w_last    = (state == S_AWW) && !w_done;
    assign bus.w_data    = data_q;

    assign bus.b_ready   = (state == S_B);

    assign bus.rack      = (state == S_ACK) && is_read;
    assign bus.wack      = (state == S_ACK) && !is_read;
    assign ace_ready     = (state == S_ACK);
    assign state_dbg     = state;

endmodule
